mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multi-cycle main controller for the single-issue RV32I datapath.
- Sequences fetch, decode, execute, memory and writeback around the shared ALU, register file, immediate generator and memory ports.
- Drives every datapath enable and mux select, and handles memory ready-handshakes with a watchdog.
- On an illegal opcode or bus timeout, traps and halts until reset.

Parameters:
- TIMEOUT_CYCLES, 16: max consecutive not-ready cycles in FETCH/MEM before trapping; 0 disables the watchdog.
- CNT_W, 5: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- instr_i  in  32  instruction register contents, valid from DECODE onward
- br_taken_i  in  1  branch comparator result, valid in EXEC
- imem_ready_i  in  1  instruction memory data valid
- dmem_ready_i  in  1  data memory access complete
- imem_req_o  out  1  instruction fetch request
- dmem_req_o  out  1  data memory request
- dmem_we_o  out  1  data memory write (store)
- ir_we_o  out  1  instruction register load strobe
- pc_we_o  out  1  PC update strobe
- pc_sel_o  out  2  0 = pc+4, 1 = pc+imm (branch/JAL), 2 = (rs1+imm)&~1 (JALR)
- alu_src_a_o  out  1  0 = rs1, 1 = pc
- alu_src_b_o  out  1  0 = rs2, 1 = imm
- rf_we_o  out  1  register file write enable
- wb_sel_o  out  2  0 = alu, 1 = mem, 2 = pc+4, 3 = imm
- retire_o  out  1  one-cycle pulse per completed instruction
- illegal_o  out  1  sticky: illegal opcode trap
- bus_err_o  out  1  sticky: memory timeout trap
- state_o  out  3  current state encoding, for debug

Behaviour:
- States and encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 7.
- Reset:
  - rst is sampled at the clock edge. While rst is high, all outputs are 0 and state_o = 0.
  - On the clock after rst deasserts, the FSM is in FETCH and imem_req_o = 1.
  - rst mid-operation aborts any pending request; requests drop at the next edge.
  - illegal_o, bus_err_o and the watchdog counter all clear on reset.
- Opcodes:
  - R = 0110011, I = 0010011, L = 0000011, S = 0100011, B = 1100011
  - JAL = 1101111, JALR = 1100111, LUI = 0110111, AUIPC = 0010111
  - Any other value is illegal.
- FETCH:
  - imem_req_o = 1.
  - When imem_ready_i = 1: ir_we_o = 1 in the same cycle (Mealy); next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle. Illegal opcode -> TRAP and set illegal_o. Otherwise -> EXEC.
- EXEC: one cycle.
  - alu_src_a_o = 1 for AUIPC, B, JAL; else 0.
  - alu_src_b_o = 0 for R and B; else 1.
  - B: pc_we_o = 1, pc_sel_o = br_taken_i ? 1 : 0, retire_o = 1, next FETCH.
  - L or S: next MEM.
  - All other opcodes: next WB.
- MEM:
  - dmem_req_o = 1; dmem_we_o = 1 only for S.
  - Wait for dmem_ready_i.
  - On ready with S: pc_we_o = 1, pc_sel_o = 0, retire_o = 1, next FETCH.
  - On ready with L: next WB.
- WB: one cycle.
  - rf_we_o = 1 only if instr_i[11:7] != 0.
  - wb_sel_o: L = 1; JAL/JALR = 2; LUI = 3; else 0.
  - pc_we_o = 1; pc_sel_o: JAL = 1, JALR = 2, else 0.
  - retire_o = 1; next FETCH.
- Datapath signals are held stable for the whole EXEC/MEM/WB sequence of an instruction.
- Default values: all strobes and selects not driven by the current state are 0.
- Latency with ready returned in the request cycle:
  - B = 3 cycles
  - R/I/LUI/AUIPC/JAL/JALR/S = 4 cycles
  - L = 5 cycles
  - Each not-ready cycle adds one cycle.
- Watchdog:
  - The counter clears on every state change.
  - In FETCH/MEM it increments on each cycle with ready = 0.
  - If ready = 0 and count == TIMEOUT_CYCLES-1: next state TRAP and set bus_err_o. A ready arriving in that same cycle wins, so there is no trap.
- TRAP:
  - All strobes and requests are 0; state_o = 7.
  - Stays in TRAP until rst. Sticky flags hold.
- Ready signals arriving outside their request state are ignored.

Test Plan:
- R-type add x3,x1,x2 (0x002081B3), ready same cycle -> states 0,1,2,4; in WB rf_we_o = 1, wb_sel_o = 0, pc_sel_o = 0; retire_o pulses once at cycle 4.
- Load 0x0000A103, dmem_ready_i delayed 3 cycles -> dmem_req_o high 4 cycles, dmem_we_o = 0; WB has wb_sel_o = 1, rf_we_o = 1; 8 cycles total.
- Branch with br_taken_i = 1 -> EXEC pc_we_o = 1, pc_sel_o = 1, no WB, retire at cycle 3. Repeat with br_taken_i = 0 -> pc_sel_o = 0.
- JAL x0 (rd = 0) -> rf_we_o stays 0, pc_sel_o = 1. JALR x1 -> pc_sel_o = 2, wb_sel_o = 2, rf_we_o = 1.
- Opcode 0x7F -> TRAP after DECODE, illegal_o = 1, no further imem_req_o. rst then returns to FETCH with illegal_o = 0.
- imem_ready_i held 0 with TIMEOUT_CYCLES = 16 -> TRAP entered after 16 FETCH cycles, bus_err_o = 1. Variant: ready on the 16th cycle -> no trap. Variant: rst asserted during MEM wait -> next cycle dmem_req_o = 0, then FETCH.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle RV32I main controller FSM with memory watchdog
//
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) around the shared datapath.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   instr_i                      instruction register contents (valid from DECODE)
//   br_taken_i                   branch comparator result (valid in EXEC)
//   imem_ready_i, dmem_ready_i   memory handshakes
//   imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, pc_sel_o,
//   alu_src_a_o, alu_src_b_o, rf_we_o, wb_sel_o, retire_o   datapath control
//   illegal_o, bus_err_o         sticky trap flags
//   state_o                      current state encoding
module mc_ctrl_fsm #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_i,
    input  logic        br_taken_i,
    input  logic        imem_ready_i,
    input  logic        dmem_ready_i,
    output logic        imem_req_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_sel_o,
    output logic        alu_src_a_o,
    output logic        alu_src_b_o,
    output logic        rf_we_o,
    output logic [1:0]  wb_sel_o,
    output logic        retire_o,
    output logic        illegal_o,
    output logic        bus_err_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // Count value of the last tolerated not-ready cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;

    logic [6:0] opcode;
    logic       is_r, is_i, is_l, is_s, is_b, is_jal, is_jalr, is_lui, is_auipc, legal;
    logic       rd_nz, waiting, timeout;
    logic       unused_instr;

    assign opcode       = instr_i[6:0];
    assign rd_nz        = (instr_i[11:7] != 5'd0);
    assign unused_instr = ^instr_i[31:12];

    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);
    assign is_l     = (opcode == OP_L);
    assign is_s     = (opcode == OP_S);
    assign is_b     = (opcode == OP_B);
    assign is_jal   = (opcode == OP_JAL);
    assign is_jalr  = (opcode == OP_JALR);
    assign is_lui   = (opcode == OP_LUI);
    assign is_auipc = (opcode == OP_AUIPC);
    assign legal    = is_r | is_i | is_l | is_s | is_b | is_jal | is_jalr | is_lui | is_auipc;

    assign waiting = ((state_q == S_FETCH) && !imem_ready_i) ||
                     ((state_q == S_MEM)   && !dmem_ready_i);
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        illegal_d   = illegal_q;
        bus_err_d   = bus_err_q;
        imem_req_o  = 1'b0;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        ir_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        pc_sel_o    = 2'd0;
        alu_src_a_o = 1'b0;
        alu_src_b_o = 1'b0;
        rf_we_o     = 1'b0;
        wb_sel_o    = 2'd0;
        retire_o    = 1'b0;

        // ALU operand selects stay valid through EXEC, MEM and WB.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            alu_src_a_o = is_auipc | is_b | is_jal;
            alu_src_b_o = !(is_r | is_b);
        end

        case (state_q)
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ready_i) begin
                    ir_we_o = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_b) begin
                    pc_we_o  = 1'b1;
                    pc_sel_o = br_taken_i ? 2'd1 : 2'd0;
                    retire_o = 1'b1;
                    state_d  = S_FETCH;
                end else if (is_l || is_s) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = is_s;
                if (dmem_ready_i) begin
                    if (is_s) begin
                        pc_we_o  = 1'b1;
                        retire_o = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            S_WB: begin
                rf_we_o  = rd_nz;
                wb_sel_o = is_l ? 2'd1 : (is_jal | is_jalr) ? 2'd2 : is_lui ? 2'd3 : 2'd0;
                pc_we_o  = 1'b1;
                pc_sel_o = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
                retire_o = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP: begin
            end
            default: state_d = S_FETCH;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // While reset is held every output reads zero, including the flags.
        if (rst) begin
            imem_req_o  = 1'b0;
            dmem_req_o  = 1'b0;
            dmem_we_o   = 1'b0;
            ir_we_o     = 1'b0;
            pc_we_o     = 1'b0;
            pc_sel_o    = 2'd0;
            alu_src_a_o = 1'b0;
            alu_src_b_o = 1'b0;
            rf_we_o     = 1'b0;
            wb_sel_o    = 2'd0;
            retire_o    = 1'b0;
        end
    end

    assign illegal_o = illegal_q & !rst;
    assign bus_err_o = bus_err_q & !rst;
    assign state_o   = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        br_taken = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_a, alu_b, rf_we, retire;
    logic        illegal, bus_err;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .instr_i(instr), .br_taken_i(br_taken),
        .imem_ready_i(imem_ready), .dmem_ready_i(dmem_ready),
        .imem_req_o(imem_req), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
        .ir_we_o(ir_we), .pc_we_o(pc_we), .pc_sel_o(pc_sel),
        .alu_src_a_o(alu_a), .alu_src_b_o(alu_b), .rf_we_o(rf_we),
        .wb_sel_o(wb_sel), .retire_o(retire), .illegal_o(illegal),
        .bus_err_o(bus_err), .state_o(state)
    );

    // {imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, alu_a, alu_b, rf_we, wb_sel, retire, illegal, bus_err, state}
    wire [17:0] obs = {imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, alu_a, alu_b,
                       rf_we, wb_sel, retire, illegal, bus_err, state};

    function automatic logic [17:0] pk(logic im, logic ir, logic dr, logic dw, logic pw,
                                       logic [1:0] ps, logic a, logic b, logic rw,
                                       logic [1:0] ws, logic rt, logic il, logic be,
                                       logic [2:0] st);
        return {im, ir, dr, dw, pw, ps, a, b, rw, ws, rt, il, be, st};
    endfunction

    logic [17:0] F_RDY, F_IDLE, DEC;

    // One reset cycle, then release: the release cycle is the first FETCH cycle.
    task automatic test_reset(string name);
        @(negedge clk); rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; #1;
        n_cmp++;
        if (obs !== 18'h0) begin n_err++; $display("FAIL %s_hold obs=%h exp=%h", name, obs, 18'h0); end
        @(negedge clk); rst = 1'b0; #1;
        n_cmp++;
        if (obs !== F_IDLE) begin n_err++; $display("FAIL %s_release obs=%h exp=%h", name, obs, F_IDLE); end
    endtask

    task automatic test_r_type();
        logic [17:0] e [5];
        logic [4:0]  im = 5'b01111;
        logic [4:0]  dm = 5'b01110;
        instr = 32'h002081B3;
        e = '{F_RDY, DEC, pk(0,0,0,0,0,0,0,0,0,0,0,0,0,2),
              pk(0,0,0,0,1,0,0,0,1,0,1,0,0,4), F_IDLE};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); imem_ready = im[i]; dmem_ready = dm[i]; #1;
            n_cmp++;
            if (obs !== e[i]) begin n_err++; $display("FAIL r_type cyc%0d obs=%h exp=%h", i, obs, e[i]); end
        end
    endtask

    task automatic test_load();
        logic [17:0] e [9];
        logic [17:0] mem_w = pk(0,0,1,0,0,0,0,1,0,0,0,0,0,3);
        instr = 32'h0000A103;
        e = '{F_RDY, DEC, pk(0,0,0,0,0,0,0,1,0,0,0,0,0,2), mem_w, mem_w, mem_w, mem_w,
              pk(0,0,0,0,1,0,0,1,1,1,1,0,0,4), F_IDLE};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); imem_ready = (i == 0); dmem_ready = (i == 6); #1;
            n_cmp++;
            if (obs !== e[i]) begin n_err++; $display("FAIL load cyc%0d obs=%h exp=%h", i, obs, e[i]); end
        end
    endtask

    task automatic test_store_fetch_stall();
        logic [17:0] e [6];
        instr = 32'h0020A023;
        e = '{F_IDLE, F_RDY, DEC, pk(0,0,0,0,0,0,0,1,0,0,0,0,0,2),
              pk(0,0,1,1,1,0,0,1,0,0,1,0,0,3), F_IDLE};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); imem_ready = (i == 1); dmem_ready = (i == 4); #1;
            n_cmp++;
            if (obs !== e[i]) begin n_err++; $display("FAIL store cyc%0d obs=%h exp=%h", i, obs, e[i]); end
        end
    endtask

    task automatic test_branch();
        logic [17:0] e [4];
        instr = 32'h00208463;
        for (int t = 1; t >= 0; t--) begin
            br_taken = t[0];
            e = '{F_RDY, DEC, pk(0,0,0,0,1,{1'b0, t[0]},1,0,0,0,1,0,0,2), F_IDLE};
            for (int i = 0; i < 4; i++) begin
                @(negedge clk); imem_ready = (i == 0); dmem_ready = 1'b0; #1;
                n_cmp++;
                if (obs !== e[i]) begin
                    n_err++; $display("FAIL branch_t%0d cyc%0d obs=%h exp=%h", t, i, obs, e[i]);
                end
            end
        end
        br_taken = 1'b0;
    endtask

    task automatic test_wb_path(string name, logic [31:0] ins, logic [17:0] ex, logic [17:0] wb);
        logic [17:0] e [5];
        instr = ins;
        e = '{F_RDY, DEC, ex, wb, F_IDLE};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); imem_ready = (i == 0); dmem_ready = 1'b0; #1;
            n_cmp++;
            if (obs !== e[i]) begin n_err++; $display("FAIL %s cyc%0d obs=%h exp=%h", name, i, obs, e[i]); end
        end
    endtask

    task automatic test_illegal();
        logic [17:0] trap = pk(0,0,0,0,0,0,0,0,0,0,0,1,0,7);
        logic [17:0] e [4];
        instr = 32'h0000007F;
        e = '{F_RDY, DEC, trap, trap};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); imem_ready = (i != 1); dmem_ready = (i == 3); #1;
            n_cmp++;
            if (obs !== e[i]) begin n_err++; $display("FAIL illegal cyc%0d obs=%h exp=%h", i, obs, e[i]); end
        end
        test_reset("illegal_rst");
    endtask

    task automatic test_fetch_timeout();
        logic [17:0] trap = pk(0,0,0,0,0,0,0,0,0,0,0,0,1,7);
        test_reset("wd_pre");
        for (int i = 2; i <= 16; i++) begin
            @(negedge clk); imem_ready = 1'b0; #1;
            n_cmp++;
            if (obs !== F_IDLE) begin n_err++; $display("FAIL wd_fetch cyc%0d obs=%h exp=%h", i, obs, F_IDLE); end
        end
        for (int i = 17; i <= 18; i++) begin
            @(negedge clk); imem_ready = (i == 18); #1;
            n_cmp++;
            if (obs !== trap) begin n_err++; $display("FAIL wd_trap cyc%0d obs=%h exp=%h", i, obs, trap); end
        end
        test_reset("wd_rst");
    endtask

    task automatic test_ready_at_limit();
        instr = 32'h002081B3;
        test_reset("lim_pre");
        for (int i = 2; i <= 15; i++) begin
            @(negedge clk); imem_ready = 1'b0; #1;
            n_cmp++;
            if (obs !== F_IDLE) begin n_err++; $display("FAIL lim_fetch cyc%0d obs=%h exp=%h", i, obs, F_IDLE); end
        end
        @(negedge clk); imem_ready = 1'b1; #1;
        n_cmp++;
        if (obs !== F_RDY) begin n_err++; $display("FAIL lim_ready obs=%h exp=%h", obs, F_RDY); end
        @(negedge clk); imem_ready = 1'b0; #1;
        n_cmp++;
        if (obs !== DEC) begin n_err++; $display("FAIL lim_decode obs=%h exp=%h", obs, DEC); end
        test_reset("lim_rst");
    endtask

    task automatic test_rst_in_mem();
        logic [17:0] e [4];
        instr = 32'h0000A103;
        e = '{F_RDY, DEC, pk(0,0,0,0,0,0,0,1,0,0,0,0,0,2), pk(0,0,1,0,0,0,0,1,0,0,0,0,0,3)};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); imem_ready = (i == 0); dmem_ready = 1'b0; #1;
            n_cmp++;
            if (obs !== e[i]) begin n_err++; $display("FAIL rst_mem cyc%0d obs=%h exp=%h", i, obs, e[i]); end
        end
        test_reset("rst_mem");
    endtask

    initial begin
        F_RDY  = pk(1,1,0,0,0,0,0,0,0,0,0,0,0,0);
        F_IDLE = pk(1,0,0,0,0,0,0,0,0,0,0,0,0,0);
        DEC    = pk(0,0,0,0,0,0,0,0,0,0,0,0,0,1);
        test_reset("reset");
        test_r_type();
        test_load();
        test_store_fetch_stall();
        test_branch();
        test_wb_path("jal_x0", 32'h0080006F, pk(0,0,0,0,0,0,1,1,0,0,0,0,0,2),
                     pk(0,0,0,0,1,1,1,1,0,2,1,0,0,4));
        test_wb_path("jalr_x1", 32'h000100E7, pk(0,0,0,0,0,0,0,1,0,0,0,0,0,2),
                     pk(0,0,0,0,1,2,0,1,1,2,1,0,0,4));
        test_wb_path("lui_x1", 32'h123450B7, pk(0,0,0,0,0,0,0,1,0,0,0,0,0,2),
                     pk(0,0,0,0,1,0,0,1,1,3,1,0,0,4));
        test_wb_path("auipc_x1", 32'h00001097, pk(0,0,0,0,0,0,1,1,0,0,0,0,0,2),
                     pk(0,0,0,0,1,0,1,1,1,0,1,0,0,4));
        test_illegal();
        test_fetch_timeout();
        test_ready_at_limit();
        test_rst_in_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
